// File: rtl/fir_frame_counter.sv
// fir_frame_counter
//   Frame/sample counter for the FIR datapath. Counts accepted beats that
//   arrive round-robin over NUM_CH interleaved channels. A frame completes
//   after FRAME_LEN full sample sets. Completed frames are counted, and a
//   sticky flag records when that count wraps. In one-shot mode the counter
//   halts after each frame and applies back-pressure until start or clr.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-low reset
//   clr        sync clear of samp_cnt/ch_idx/halt (frm_cnt, frm_ovf kept)
//   one_shot   0 = auto-reload, 1 = halt after each frame
//   start      restart pulse, only honoured while halted
//   fir_valid  input beat valid
//   fir_ready  beat accepted when fir_valid & fir_ready
//   ch_idx     channel of the next beat to be accepted
//   samp_cnt   completed sample sets in the current frame, 0..FRAME_LEN
//   frame_done samp_cnt == FRAME_LEN
//   frm_cnt    completed frames, wraps modulo 2^FRM_W
//   frm_ovf    sticky, set when frm_cnt wraps
module fir_frame_counter #(
    parameter int FRAME_LEN = 16,
    parameter int NUM_CH    = 1,
    parameter int FRM_W     = 8,
    localparam int CNT_W    = $clog2(FRAME_LEN + 1),
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             one_shot,
    input  logic             start,
    input  logic             fir_valid,
    output logic             fir_ready,
    output logic [CH_W-1:0]  ch_idx,
    output logic [CNT_W-1:0] samp_cnt,
    output logic             frame_done,
    output logic [FRM_W-1:0] frm_cnt,
    output logic             frm_ovf
);

    typedef enum logic {RUN, HALT} state_t;

    state_t           state, state_nxt;
    logic [CH_W-1:0]  ch_nxt;
    logic [CNT_W-1:0] samp_nxt;
    logic [CNT_W-1:0] base;
    logic [FRM_W-1:0] frm_nxt;
    logic             ovf_nxt;
    logic             accept;
    logic             wrap;
    logic             completes;

    assign fir_ready  = (state == RUN);
    assign frame_done = (samp_cnt == CNT_W'(FRAME_LEN));
    assign accept     = fir_valid & fir_ready;
    assign wrap       = (ch_idx == CH_W'(NUM_CH - 1));
    // A finished frame restarts from zero on the next accepted beat.
    assign base       = frame_done ? '0 : samp_cnt;
    assign completes  = wrap && (base == CNT_W'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            ch_idx   <= '0;
            samp_cnt <= '0;
            frm_cnt  <= '0;
            frm_ovf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ch_idx   <= ch_nxt;
            samp_cnt <= samp_nxt;
            frm_cnt  <= frm_nxt;
            frm_ovf  <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch_idx;
        samp_nxt  = samp_cnt;
        frm_nxt   = frm_cnt;
        ovf_nxt   = frm_ovf;
        if (clr) begin
            // Clear beats any concurrent beat; that beat is dropped.
            state_nxt = RUN;
            ch_nxt    = '0;
            samp_nxt  = '0;
        end else if (start && state == HALT) begin
            state_nxt = RUN;
            ch_nxt    = '0;
            samp_nxt  = '0;
        end else if (accept) begin
            ch_nxt   = wrap ? '0 : ch_idx + CH_W'(1);
            samp_nxt = base + CNT_W'(wrap);
            if (completes) begin
                frm_nxt = frm_cnt + FRM_W'(1);
                if (&frm_cnt) ovf_nxt = 1'b1;
                // one_shot only matters on the beat that finishes the frame.
                if (one_shot) state_nxt = HALT;
            end
        end
    end

endmodule
